clk_div_ctrl: RTL

- Run-time controller for the lab clock divider: generates a divided clock of programmable ratio N from the system clock.
- Sequences start and stop cleanly and accepts new ratios over a valid/ready handshake.
- Applies every change only at a period boundary, so div_clk never produces a runt pulse.
- Drives a board GPIO pin plus a one-cycle tick for downstream logic.

---
 rtl/clk_div_ctrl_if.sv | 26 ++
 rtl/clk_div_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl_if.sv
// Ratio configuration channel for clk_div_ctrl: valid/ready transfer of a new
// divide ratio plus a one-cycle reject strobe back to the requester.
interface clk_div_ctrl_if #(
    parameter int WIDTH = 16
) ();
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    // Requester side: offers ratios, observes acceptance and rejection
    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    // Controller side
    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time clock divider controller. Produces div_clk of ratio N (high for
// ceil(N/2) cycles) plus a tick in the last cycle of each period. Start, stop
// and ratio changes take effect only at period boundaries, so no runt pulses.
// All visible outputs are registered views of the state/counter of the
// previous cycle: en sampled at edge k gives div_clk=1 from edge k+1.
module clk_div_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    clk_div_ctrl_if.slave        cfg,
    output logic                 div_clk,
    output logic                 tick,
    output logic                 running
);

    localparam logic [WIDTH-1:0] DEF_N   = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] n_reg, n_next;
    logic             pend_valid_reg, pend_valid_next;
    logic [WIDTH-1:0] pend_div_reg, pend_div_next;

    logic             div_clk_reg, div_clk_next;
    logic             tick_reg, tick_next;
    logic             running_reg, running_next;
    logic             cfg_err_reg, cfg_err_next;

    logic             active;
    logic             wrap;
    logic             accept;
    logic             bad_div;
    logic [WIDTH:0]   half;

    // One extra bit keeps (N+1)/2 exact for N = 2^WIDTH-1
    assign half    = ({1'b0, n_reg} + (WIDTH+1)'(1)) >> 1;
    assign active  = (state_reg != IDLE);
    assign wrap    = active && (cnt_reg == (n_reg - ONE));
    assign accept  = cfg.cfg_valid && !pend_valid_reg;
    assign bad_div = cfg.cfg_div < MIN_DIV;

    assign cfg.cfg_ready = !pend_valid_reg;
    assign cfg.cfg_err   = cfg_err_reg;
    assign div_clk       = div_clk_reg;
    assign tick          = tick_reg;
    assign running       = running_reg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: stops and restarts only resolve at the period wrap
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = wrap ? IDLE : STOP_PEND;
                end
            end
            STOP_PEND: begin
                if (en) begin
                    state_next = RUN;
                end else if (wrap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter, active ratio and pending slot; a handshake on the wrap edge
    // lands in the slot and waits for the following wrap
    always_comb begin
        cnt_next        = cnt_reg;
        n_next          = n_reg;
        pend_valid_next = pend_valid_reg;
        pend_div_next   = pend_div_reg;

        if (!active || wrap) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + ONE;
        end

        if (wrap && pend_valid_reg) begin
            n_next          = pend_div_reg;
            pend_valid_next = 1'b0;
        end

        if (accept && !bad_div) begin
            if (!active) begin
                n_next = cfg.cfg_div;
            end else begin
                pend_valid_next = 1'b1;
                pend_div_next   = cfg.cfg_div;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg        <= '0;
            n_reg          <= DEF_N;
            pend_valid_reg <= 1'b0;
            pend_div_reg   <= '0;
        end else begin
            cnt_reg        <= cnt_next;
            n_reg          <= n_next;
            pend_valid_reg <= pend_valid_next;
            pend_div_reg   <= pend_div_next;
        end
    end

    // Output decode from the current state and count
    always_comb begin
        div_clk_next = active && ({1'b0, cnt_reg} < half);
        tick_next    = wrap;
        running_next = active;
        cfg_err_next = accept && bad_div;
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_clk_reg <= 1'b0;
            tick_reg    <= 1'b0;
            running_reg <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            div_clk_reg <= div_clk_next;
            tick_reg    <= tick_next;
            running_reg <= running_next;
            cfg_err_reg <= cfg_err_next;
        end
    end

endmodule
